// File: rtl/sid_reg_writer.sv
// sid_reg_writer: queues host register writes and replays them onto the SID
// write bus as single-cycle strobes separated by a fixed idle gap. Every
// committed write is mirrored in a shadow file for host readback. The
// chip-generated registers (POTX/POTY/OSC3/ENV3) are read from live inputs.
module sid_reg_writer #(
  parameter int DEPTH = 8,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [4:0]               iAddr,
  input  logic [7:0]               iData,
  input  logic                     iPause,
  input  logic                     iRdReq,
  input  logic [4:0]               iRdAddr,
  output logic                     oRdValid,
  output logic [7:0]               oRdData,
  input  logic [7:0]               iPotX,
  input  logic [7:0]               iPotY,
  input  logic [7:0]               iOsc3,
  input  logic [7:0]               iEnv3,
  output logic                     oWE,
  output logic [4:0]               oAddr,
  output logic [7:0]               oData,
  output logic [$clog2(DEPTH):0]   oLevel
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [3:0]    GAP_L   = 4'(GAP - 1);
  localparam int            NSHADOW = 29;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

  state_t          state;
  logic [3:0]      gcnt;
  logic [4:0]      mem_a [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic [7:0]      shadow [NSHADOW];
  logic            push, pop;

  assign oReady = (count < DEPTH_L);
  assign oLevel = count;
  assign push   = iValid && oReady;
  // A strobe may start from IDLE or at the end of the gap; pause only
  // blocks starting a new one, never shortens WRITE or GAP.
  assign pop    = (count != '0) && !iPause &&
                  ((state == S_IDLE) || ((state == S_GAP) && (gcnt == 4'd0)));

  // FIFO storage: payload needs no reset, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr] <= iAddr;
      mem_d[wptr] <= iData;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Write sequencer: IDLE -> WRITE (one-cycle strobe) -> GAP -> WRITE/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      oWE   <= 1'b0;
      oAddr <= '0;
      oData <= '0;
      gcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            oAddr <= mem_a[rptr];
            oData <= mem_d[rptr];
            oWE   <= 1'b1;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          oWE   <= 1'b0;
          gcnt  <= GAP_L;
          state <= S_GAP;
        end
        S_GAP: begin
          if (gcnt != 4'd0) begin
            gcnt <= gcnt - 4'd1;
          end else if (pop) begin
            oAddr <= mem_a[rptr];
            oData <= mem_d[rptr];
            oWE   <= 1'b1;
            state <= S_WRITE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          oWE   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Shadow file: commit the strobed write at the end of its WRITE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSHADOW; i++) shadow[i] <= 8'h00;
    end else if ((state == S_WRITE) && (oAddr < 5'h1D)) begin
      shadow[oAddr] <= oData;
    end
  end

  // Readback: one-cycle latency, reads see the shadow before any same-edge commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oRdValid <= 1'b0;
      oRdData  <= 8'h00;
    end else begin
      oRdValid <= iRdReq;
      if (iRdReq) begin
        case (iRdAddr)
          5'h19:                oRdData <= iPotX;
          5'h1A:                oRdData <= iPotY;
          5'h1B:                oRdData <= iOsc3;
          5'h1C:                oRdData <= iEnv3;
          5'h1D, 5'h1E, 5'h1F:  oRdData <= 8'h00;
          default:              oRdData <= shadow[iRdAddr];
        endcase
      end
    end
  end

endmodule
